// File: rtl/inst_rom_loader.sv
// Loadable instruction ROM: streams a length-prefixed big-endian image into memory,
// holds the core in reset until the image is complete, then serves fetch reads.
module inst_rom_loader #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid_i,
    input  logic [7:0]  ld_data_i,
    output logic        ld_ready_o,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    output logic        core_rst_o,
    output logic        load_done_o,
    output logic        load_err_o
);

    // state  | meaning
    // HDR_HI | waiting for length header high byte
    // HDR_LO | waiting for length header low byte
    // DATA   | receiving image bytes, 4 per word
    // RUN    | image loaded, core released, fetch port live
    // ERR    | header length exceeded memory depth

    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, RUN, ERR} state_t;

    localparam int             MEM_DEPTH = 1 << ADDR_W;
    localparam logic [LEN_W:0] DEPTH_EXT = (LEN_W+1)'(1) << ADDR_W;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   len, len_nxt;
    logic [LEN_W-1:0]   waddr, waddr_nxt;
    logic [1:0]         bcnt, bcnt_nxt;
    logic [23:0]        word_buf, word_buf_nxt;
    logic               mem_we;
    logic [LEN_W-1:0]   len_full;
    logic               xfer;

    logic [31:0] mem [0:MEM_DEPTH-1];

    assign ld_ready_o  = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
    assign core_rst_o  = (state != RUN);
    assign load_done_o = (state == RUN);
    assign load_err_o  = (state == ERR);
    assign xfer        = ld_valid_i & ld_ready_o;
    assign len_full    = {len[15:8], ld_data_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HDR_HI;
            len      <= '0;
            waddr    <= '0;
            bcnt     <= '0;
            word_buf <= '0;
        end else begin
            state    <= state_nxt;
            len      <= len_nxt;
            waddr    <= waddr_nxt;
            bcnt     <= bcnt_nxt;
            word_buf <= word_buf_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        len_nxt      = len;
        waddr_nxt    = waddr;
        bcnt_nxt     = bcnt;
        word_buf_nxt = word_buf;
        mem_we       = 1'b0;
        case (state)
            HDR_HI: begin
                if (xfer) begin
                    len_nxt[15:8] = ld_data_i;
                    state_nxt     = HDR_LO;
                end
            end
            HDR_LO: begin
                if (xfer) begin
                    len_nxt = len_full;
                    if (len_full == '0) begin
                        state_nxt = RUN;
                    end else if ({1'b0, len_full} > DEPTH_EXT) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = DATA;
                        waddr_nxt = '0;
                        bcnt_nxt  = '0;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    word_buf_nxt = {word_buf[15:0], ld_data_i};
                    bcnt_nxt     = bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        mem_we    = 1'b1;
                        waddr_nxt = waddr + LEN_W'(1);
                        bcnt_nxt  = '0;
                        if (waddr == len - LEN_W'(1)) begin
                            state_nxt = RUN;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // No reset on the array so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr[ADDR_W-1:0]] <= {word_buf, ld_data_i};
        end
    end

    logic [ADDR_W-1:0] idx;
    logic [LEN_W-1:0]  idx_ext;
    logic              unused_addr_bits;

    assign idx              = rom_addr_i[ADDR_W+1:2];
    assign idx_ext          = LEN_W'(idx);
    assign unused_addr_bits = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};

    // Words beyond len may hold stale data from an earlier load; mask them.
    assign rom_data_o = (state == RUN && rom_ce_i && idx_ext < len) ? mem[idx] : 32'h0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: normal, stalled, empty, full, oversize,
// and reset-interrupted loads, plus fetch masking and address wrap.
module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid_i;
    logic [7:0]  ld_data_i;
    logic        ld_ready_o;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        core_rst_o;
    logic        load_done_o;
    logic        load_err_o;

    int checks   = 0;
    int failures = 0;

    inst_rom_loader #(.ADDR_W(10), .LEN_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid_i  (ld_valid_i),
        .ld_data_i   (ld_data_i),
        .ld_ready_o  (ld_ready_o),
        .rom_ce_i    (rom_ce_i),
        .rom_addr_i  (rom_addr_i),
        .rom_data_o  (rom_data_o),
        .core_rst_o  (core_rst_o),
        .load_done_o (load_done_o),
        .load_err_o  (load_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one byte at the negedge; it transfers on the following posedge.
    task automatic send_byte(input logic [7:0] b, input bit chk_hs);
        @(negedge clk);
        ld_valid_i = 1'b1;
        ld_data_i  = b;
        if (chk_hs) begin
            chk("ld_ready_during_load", ld_ready_o, 1'b1);
            chk("core_rst_during_load", core_rst_o, 1'b1);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        ld_valid_i = 1'b0;
        ld_data_i  = 8'($urandom);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        ld_valid_i = 1'b0;
        rom_ce_i   = 1'b1;
        rom_addr_i = 32'h0;
        #1;
        chk("rst_ld_ready", ld_ready_o, 1'b1);
        chk("rst_core_rst", core_rst_o, 1'b1);
        chk("rst_load_done", load_done_o, 1'b0);
        chk("rst_load_err", load_err_o, 1'b0);
        chk("rst_rom_data", rom_data_o, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic ce, input logic [31:0] exp);
        @(negedge clk);
        ld_valid_i = 1'b0;
        rom_ce_i   = ce;
        rom_addr_i = a;
        #1;
        chk(tag, rom_data_o, exp);
    endtask

    task automatic check_released(input string tag);
        @(negedge clk);
        ld_valid_i = 1'b0;
        chk({tag, "_core_rst"}, core_rst_o, 1'b0);
        chk({tag, "_load_done"}, load_done_o, 1'b1);
        chk({tag, "_ld_ready"}, ld_ready_o, 1'b0);
    endtask

    logic [7:0] img [10];
    logic [7:0] bad_hdr [2];

    initial begin
        img = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h01, 8'h34, 8'h02, 8'h00, 8'h02};
        bad_hdr = '{8'h04, 8'h01};
        rst        = 1'b1;
        ld_valid_i = 1'b0;
        ld_data_i  = 8'h0;
        rom_ce_i   = 1'b0;
        rom_addr_i = 32'h0;

        // Back-to-back two-word image
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(img[i], 1'b1);
        check_released("t1");
        rd("t1_w0", 32'h0, 1'b1, 32'h34010001);
        rd("t1_w1", 32'h4, 1'b1, 32'h34020002);
        rd("t1_w2_masked", 32'h8, 1'b1, 32'h0);
        // RUN ignores further valid bytes
        for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b0);
        check_released("t1_run_hold");
        rd("t1_w0_after", 32'h0, 1'b1, 32'h34010001);

        // Same image with stalls
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_byte(img[i], 1'b1);
            idle(1);
            if (i == 4 || i == 8) idle(5);
        end
        chk("t2_done_after_10", load_done_o, 1'b1);
        rd("t2_w0", 32'h0, 1'b1, 32'h34010001);
        rd("t2_w1", 32'h4, 1'b1, 32'h34020002);
        rd("t2_w2_masked", 32'h8, 1'b1, 32'h0);

        // Empty image
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check_released("t3");
        rd("t3_r0", 32'h0, 1'b1, 32'h0);
        rd("t3_r4", 32'h4, 1'b1, 32'h0);

        // Oversize header 0x0401
        do_reset();
        for (int i = 0; i < 2; i++) send_byte(bad_hdr[i], 1'b1);
        @(negedge clk);
        chk("t4_err", load_err_o, 1'b1);
        chk("t4_ready", ld_ready_o, 1'b0);
        ld_valid_i = 1'b1;
        repeat (100) begin
            @(negedge clk);
            ld_data_i = 8'($urandom);
        end
        chk("t4_err_hold", load_err_o, 1'b1);
        chk("t4_ready_hold", ld_ready_o, 1'b0);
        chk("t4_core_rst_hold", core_rst_o, 1'b1);
        chk("t4_done_hold", load_done_o, 1'b0);
        rd("t4_read_masked", 32'h0, 1'b1, 32'h0);

        // Full-depth image 0x0400: word w = A500_0000 | w
        do_reset();
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int w = 0; w < 1024; w++) begin
            logic [31:0] word;
            word = 32'hA500_0000 | 32'(w);
            for (int b = 3; b >= 0; b--) send_byte(word[b*8 +: 8], 1'b0);
        end
        check_released("t5");
        chk("t5_err", load_err_o, 1'b0);
        rd("t5_first", 32'h0, 1'b1, 32'hA500_0000);
        rd("t5_mid", 32'h0000_0800, 1'b1, 32'hA500_0200);
        rd("t5_last", 32'h0000_0FFC, 1'b1, 32'hA500_03FF);
        rd("t5_wrap", 32'h0000_1004, 1'b1, 32'hA500_0001);

        // Reset after 5 bytes of a 2-word load, then reload one word
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(img[i], 1'b1);
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        check_released("t6");
        rd("t6_w0", 32'h0, 1'b1, 32'hDEADBEEF);
        rd("t6_w1_masked", 32'h4, 1'b1, 32'h0);

        // Fetch enable and address wrap
        rd("t7_ce_off", 32'h0, 1'b0, 32'h0);
        rd("t7_wrap", 32'h0000_1000, 1'b1, 32'hDEADBEEF);
        rd("t7_low_bits", 32'h0000_0003, 1'b1, 32'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction memory that sits directly upstream of the processor core.
- At power-up it loads a program image from a byte-stream valid/ready interface and holds the core in reset until the image is complete.
- After loading, it serves combinational instruction reads on the core's fetch port (rom_ce/rom_addr in, rom_data out).
- This gives the core a loadable ROM without changing the core.

Parameters:
- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W 32-bit words.
- LEN_W, 16, width of the image-length header, in words.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ld_valid_i  input  1  loader byte valid.
- ld_data_i  input  8  loader byte.
- ld_ready_o  output  1  block accepts a byte this cycle.
- rom_ce_i  input  1  fetch enable from the core.
- rom_addr_i  input  32  fetch byte address from the core.
- rom_data_o  output  32  instruction word to the core.
- core_rst_o  output  1  active-high reset for the core; high until the load completes.
- load_done_o  output  1  image loaded, core released.
- load_err_o  output  1  header length exceeded depth; sticky until rst.

Behaviour:
- Handshake: a byte transfers on a rising edge where ld_valid_i & ld_ready_o. ld_data_i is ignored otherwise.
- State machine: HDR_HI, HDR_LO, DATA, RUN, ERR. Reset state is HDR_HI.
  - HDR_HI: on transfer, len[15:8] <= byte; go to HDR_LO.
  - HDR_LO: on transfer, len[7:0] <= byte.
    - If the full len == 0, go to RUN.
    - If len > 2**ADDR_W, go to ERR.
    - Otherwise go to DATA with waddr = 0 and bcnt = 0.
  - DATA: bytes arrive big-endian (first byte lands in [31:24]). On each transfer, shift into word_buf and bcnt++. On the 4th byte (bcnt == 3) the write and any state change happen on that same edge:
    - write {word_buf[23:0], byte} to mem[waddr];
    - waddr++ and bcnt <= 0;
    - if waddr == len-1, go to RUN.
  - RUN: terminal until rst. ld_ready_o is 0; ld_valid_i is ignored.
  - ERR: terminal until rst. ld_ready_o is 0, core_rst_o is 1, load_err_o is 1.
- ld_ready_o is 1 in HDR_HI, HDR_LO and DATA, and 0 otherwise. It is a function of the registered state only; there is no combinational path from ld_valid_i.
- core_rst_o = (state != RUN); load_done_o = (state == RUN). Both are decoded from registered state, so the core leaves reset in the first cycle after the edge that accepts the final byte (or the HDR_LO byte when len == 0).
- Read path, combinational:
  - idx = rom_addr_i[ADDR_W+1:2]. Bits [1:0] and bits above ADDR_W+1 are ignored, so addresses wrap modulo depth.
  - rom_data_o = mem[idx] if state == RUN && rom_ce_i && idx < len; otherwise 32'h0.
  - Words never loaded read as 0 even though the memory array itself is not cleared.
- Reset values: state HDR_HI, len 0, waddr 0, bcnt 0, word_buf 0. Outputs: ld_ready_o 1, core_rst_o 1, load_done_o 0, load_err_o 0, rom_data_o 0.
- Reset mid-load: all control registers return to reset values immediately, and the load must restart from the header. Previously written memory words are not guaranteed; they are masked by len == 0 until reloaded.
- len == 2**ADDR_W is legal and fills the whole memory. len == 2**ADDR_W + 1 goes to ERR.
- Stalled source: ld_valid_i low for any number of cycles leaves all state unchanged.
- The memory array has no reset, so it can infer block or distributed RAM. Only the write port is clocked.

Test Plan:
- Load header 0x0002, then bytes 34 01 00 01, 34 02 00 02 with valid held high.
  - ld_ready_o stays 1 for 10 cycles and core_rst_o falls the cycle after the 10th transfer.
  - rom_addr 0x0 gives 0x34010001; 0x4 gives 0x34020002; 0x8 gives 0.
- Same image with ld_valid_i toggled every other cycle and 5-cycle gaps.
  - Identical memory contents; core_rst_o deasserts only after 10 accepted bytes.
- Header 0x0000.
  - load_done_o is 1 and core_rst_o is 0 the cycle after the 2nd byte; every read returns 0.
- Header 0x0401 with ADDR_W = 10.
  - load_err_o is 1, ld_ready_o is 0 and core_rst_o stays 1 for 100 cycles; further valid bytes are ignored.
- Assert rst after 5 bytes of a 2-word load, then reload header 0x0001 with DEADBEEF.
  - Address 0x0 reads 0xDEADBEEF and address 0x4 reads 0.
- In RUN, drive rom_ce_i = 0 at address 0x0 and read 0 back; then drive rom_ce_i = 1 at address 0x00001000 (wraps to index 0) and read word 0.
